// File: rtl/bram_serial_reader.sv
// Walks START_ADDR..END_ADDR (inclusive, wrapping) on an SB_RAM40_4K 256x16 read port and
// shifts every word out MSB first. Define BRAM_READER_PARITY_EN to append an even-parity bit per word.
module bram_serial_reader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 8'h00,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 8'hFF,
  parameter int                    BIT_DIVIDE = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic                  RE,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic                  SDATA,
  output logic                  BIT_STROBE,
  output logic                  FRAME
);

`ifdef BRAM_READER_PARITY_EN
  localparam int SHIFT_W = DATA_WIDTH + 1;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  localparam int SHIFT_W = DATA_WIDTH;
`endif

  localparam int SUB_W = $clog2(BIT_DIVIDE + 1);
  localparam int BIT_W = $clog2(SHIFT_W + 1);

  localparam logic [SUB_W-1:0]      SUB_ZERO = SUB_W'(0);
  localparam logic [SUB_W-1:0]      SUB_ONE  = SUB_W'(1);
  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(BIT_DIVIDE - 1);
  localparam logic [BIT_W-1:0]      BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(SHIFT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t                state_r;
  logic                  launch_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic                  re_r;
  logic                  sdata_r;
  logic                  strobe_r;
  logic                  frame_r;
  logic [SHIFT_W-1:0]    shift_r;
  logic [SUB_W-1:0]      sub_r;
  logic [BIT_W-1:0]      bit_r;

  logic [SHIFT_W-1:0]    shift_load_s;
  logic                  sub_wrap_s;
  logic                  last_bit_s;
  logic                  last_addr_s;

  assign sub_wrap_s  = (sub_r == SUB_LAST);
  assign last_bit_s  = (bit_r == BIT_LAST);
  assign last_addr_s = (raddr_r == END_ADDR);

  // Word image loaded into the shifter when the RAM data becomes valid.
  always_comb begin
    shift_load_s = {SHIFT_W{1'b0}};
`ifdef BRAM_READER_PARITY_EN
    shift_load_s = {RDATA, even_parity(RDATA)};
`else
    shift_load_s = RDATA;
`endif
  end

  // Sequencer: a one-cycle launch after START, then fetch / wait for read latency / shift per word.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= ST_IDLE;
      launch_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      raddr_r  <= {ADDR_WIDTH{1'b0}};
      re_r     <= 1'b0;
      sdata_r  <= 1'b0;
      strobe_r <= 1'b0;
      frame_r  <= 1'b0;
      shift_r  <= {SHIFT_W{1'b0}};
      sub_r    <= SUB_ZERO;
      bit_r    <= BIT_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // done_r blocks a START that is still high on the edge right after DONE.
          if (launch_r) begin
            launch_r <= 1'b0;
            raddr_r  <= START_ADDR;
            re_r     <= 1'b1;
            state_r  <= ST_FETCH;
          end else if (START && !done_r) begin
            launch_r <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            re_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          re_r    <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          shift_r  <= shift_load_s;
          sdata_r  <= shift_load_s[SHIFT_W-1];
          strobe_r <= 1'b1;
          frame_r  <= 1'b1;
          sub_r    <= SUB_ZERO;
          bit_r    <= BIT_ZERO;
          state_r  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!sub_wrap_s) begin
            sub_r    <= sub_r + SUB_ONE;
            strobe_r <= 1'b0;
          end else if (!last_bit_s) begin
            sub_r    <= SUB_ZERO;
            bit_r    <= bit_r + BIT_ONE;
            shift_r  <= {shift_r[SHIFT_W-2:0], 1'b0};
            sdata_r  <= shift_r[SHIFT_W-2];
            strobe_r <= 1'b1;
          end else begin
            sub_r    <= SUB_ZERO;
            bit_r    <= BIT_ZERO;
            strobe_r <= 1'b0;
            frame_r  <= 1'b0;
            sdata_r  <= 1'b0;
            if (last_addr_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              raddr_r <= raddr_r + ADDR_ONE;
              re_r    <= 1'b1;
              state_r <= ST_FETCH;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          launch_r <= 1'b0;
          busy_r   <= 1'b0;
          re_r     <= 1'b0;
          sdata_r  <= 1'b0;
          strobe_r <= 1'b0;
          frame_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign RADDR      = raddr_r;
  assign RE         = re_r;
  assign SDATA      = sdata_r;
  assign BIT_STROBE = strobe_r;
  assign FRAME      = frame_r;

endmodule

// File: doc/bram_serial_reader.md
# bram_serial_reader

Read-side consumer for an SB_RAM40_4K block RAM configured as 256x16. On a start pulse it walks a programmed address range through the RAM read port, honours the RAM's one-cycle read latency, and shifts each 16-bit word out MSB-first on a single pin with a per-bit strobe and a word frame. It sits directly downstream of the RAM's RADDR/RE/RDATA port and drives a header pin or an external serial sink.

## Interface
- ADDR_WIDTH, 8, RAM read-address width (256x16 mode)
- DATA_WIDTH, 16, RAM word width; number of bits shifted per word
- START_ADDR, 8'h00, first address read
- END_ADDR, 8'hFF, last address read, inclusive
- BIT_DIVIDE, 4, CLK cycles per serial bit, must be ≥1

- CLK  in  1  single clock; also drives the RAM RCLK
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  begin a pass; sampled only in IDLE
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle pulse after the last bit of END_ADDR
- RADDR  out  ADDR_WIDTH  RAM read address, registered
- RE  out  1  RAM read enable, registered; RCLKE is tied high externally
- RDATA  in  DATA_WIDTH  RAM read data, valid the cycle after the edge that samples RE=1
- SDATA  out  1  serial data, MSB first
- BIT_STROBE  out  1  one-cycle pulse in the first cycle of every bit
- FRAME  out  1  high while any bit of a word is on SDATA

## Operation
- States: IDLE, FETCH, WAIT, SHIFT.
- IDLE: RE=0, BUSY=0, SDATA=0, FRAME=0. START=1 at an edge → FETCH, RADDR=START_ADDR, RE=1, BUSY=1.
- FETCH: one cycle; RAM captures RADDR at the closing edge → WAIT, RE=0.
- WAIT: one cycle; RDATA valid; closing edge loads the shift register and the bit and sub-bit counters → SHIFT.
- SHIFT: SDATA = shift[DATA_WIDTH-1]; each bit held BIT_DIVIDE cycles; the shift register moves left when the sub-bit counter wraps. After DATA_WIDTH bits: if RADDR==END_ADDR → IDLE with DONE=1 for one cycle; otherwise RADDR=RADDR+1 (mod 2^ADDR_WIDTH) → FETCH with RE=1.
- Wrap-around: END_ADDR < START_ADDR is legal; the address wraps from 8'hFF to 8'h00. START_ADDR==END_ADDR sends exactly one word.
- START during BUSY is ignored. START held high in IDLE on the same edge that DONE pulses has no effect; a new pass starts on the next edge on which START is high.
- Reset mid-pass: every output returns to 0 immediately and the state returns to IDLE; no DONE is issued.
- Reset values: BUSY=0, DONE=0, RADDR=0, RE=0, SDATA=0, BIT_STROBE=0, FRAME=0.

## Timing
- Edge 0 samples START=1. From edge 1, RE=1 and RADDR=START_ADDR. Edge 2 is the RAM capture edge and RE falls. RDATA is valid after edge 2. Edge 3 loads the shift register and sets FRAME=1, BIT_STROBE=1, SDATA=RDATA[15].
- Word duration: DATA_WIDTH×BIT_DIVIDE cycles of FRAME=1.
- Inter-word gap: exactly 2 cycles (FETCH, WAIT) with FRAME=0 and SDATA=0.
- Full pass of N words: 3 + N×(DATA_WIDTH×BIT_DIVIDE) + 2×(N−1) cycles from the START edge to the DONE edge.
- BIT_DIVIDE=1: BIT_STROBE stays high for the whole word.

## Configuration
- BRAM_READER_PARITY_EN defined: after each word, one extra bit of even parity over the word (XOR of all bits) is sent. This bit is BIT_DIVIDE cycles long, has BIT_STROBE and FRAME high, and makes the word duration (DATA_WIDTH+1)×BIT_DIVIDE cycles.
- Not defined: no parity bit, no parity logic; timing is as stated above.

## Test plan
- Single word: START_ADDR=END_ADDR=8'h45, RAM[0x45]=16'hA50F, BIT_DIVIDE=4 → SDATA sequence 1010010100001111 with each bit 4 cycles; 16 BIT_STROBE pulses; DONE exactly 3+64 cycles after the START edge.
- Range with latency check: addresses 0x10–0x12 holding 0x0001, 0x8000, 0xFFFF → RE pulses at cycles 1, 1+66, 1+132; serial data matches all three words; inter-word FRAME-low gap is 2 cycles.
- Wrap: START_ADDR=8'hFE, END_ADDR=8'h01 → RADDR sequence FE, FF, 00, 01 and a single DONE.
- START while busy: pulse START mid-word → no restart and no change in RADDR; the pass completes normally.
- Reset mid-SHIFT: drop RESET_N asynchronously during bit 7 → all outputs go to 0 without waiting for an edge; no DONE; a fresh START after release begins again at START_ADDR.
- With BRAM_READER_PARITY_EN, word 16'hA50F (8 ones) → 17th bit = 0; word 16'h0001 → 17th bit = 1; the frame is 68 cycles when BIT_DIVIDE=4.
